score_display_unit: RTL and testbench

Elapsed-time score display: while `status` is high, a BCD score (0000–9999) advances once per second, and the value is shown on a 4-digit, time-multiplexed, common-anode 7-segment display. The 1 Hz tick and the digit-refresh strobe are both derived internally from the single system clock. It sits between game/status control logic and the board's anode and segment pins.

---
 rtl/score_display_pkg.sv | 28 ++
 rtl/score_display_unit_bcd_to_7seg.sv | 28 ++
 rtl/score_display_unit.sv | 111 +++++++++++
 tb/tb_score_display_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/score_display_pkg.sv
// Shared types and constants for the elapsed-time score display.
//   bcd_t      : one BCD digit (0-9 in normal use)
//   SEG_*      : active-low abcdefg segment patterns (bit 6 = a ... bit 0 = g)
//   AN_DIG*    : active-low one-cold anode enables (DIG3 = leftmost/thousands)
package score_display_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_DIG3 = 4'b0111;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG0 = 4'b1110;

endpackage

// File: rtl/score_display_unit_bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder.
//   digit : 4-bit BCD input
//   seg   : abcdefg pattern, active-low; non-decimal codes blank the digit
module bcd_to_7seg
    import score_display_pkg::*;
(
    input  bcd_t       digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display_unit.sv
// Elapsed-time BCD score (0000-9999, +1 per second while status=1) shown on a
// 4-digit time-multiplexed common-anode 7-segment display.
//   clk_100MHz     : system clock, rising edge
//   reset          : synchronous, active-low
//   status         : 1 = counting, 0 = paused (score and prescaler phase held)
//   Anode_Activate : active-low digit enables, bit 3 = thousands (registered)
//   LED_out        : active-low abcdefg segments (registered)
module score_display_unit
    import score_display_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned REFRESH_BITS = 20
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       status,
    output logic [3:0] Anode_Activate,
    output logic [6:0] LED_out
);

    localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

    logic [PRE_W-1:0]        pre;
    logic                    tick_c;
    bcd_t                    ones, tens, hund, thou;
    logic [REFRESH_BITS-1:0] refresh;
    logic [1:0]              sel_c;
    bcd_t                    digit_c;
    logic [3:0]              an_c;
    logic [6:0]              seg_c;

    // One-second tick; only fires while running so a pause freezes the phase.
    assign tick_c = status && (pre == PRE_LAST);

    // Prescaler: counts only while running, wraps on the tick.
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            pre <= '0;
        end else if (status) begin
            pre <= tick_c ? '0 : pre + PRE_W'(1);
        end
    end

    // Four-digit BCD counter with decimal carry; 9999 wraps to 0000.
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            ones <= '0;
            tens <= '0;
            hund <= '0;
            thou <= '0;
        end else if (tick_c) begin
            if (ones != BCD_MAX) begin
                ones <= ones + 4'd1;
            end else begin
                ones <= '0;
                if (tens != BCD_MAX) begin
                    tens <= tens + 4'd1;
                end else begin
                    tens <= '0;
                    if (hund != BCD_MAX) begin
                        hund <= hund + 4'd1;
                    end else begin
                        hund <= '0;
                        thou <= (thou != BCD_MAX) ? thou + 4'd1 : 4'd0;
                    end
                end
            end
        end
    end

    // Free-running refresh counter; top two bits pick the digit slot.
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            refresh <= '0;
        end else begin
            refresh <= refresh + REFRESH_BITS'(1);
        end
    end

    assign sel_c = refresh[REFRESH_BITS-1 -: 2];

    // Slot mux: thousands first, ones last.
    always_comb begin
        an_c    = AN_DIG0;
        digit_c = ones;
        case (sel_c)
            2'd0: begin an_c = AN_DIG3; digit_c = thou; end
            2'd1: begin an_c = AN_DIG2; digit_c = hund; end
            2'd2: begin an_c = AN_DIG1; digit_c = tens; end
            default: begin an_c = AN_DIG0; digit_c = ones; end
        endcase
    end

    bcd_to_7seg u_dec (
        .digit (digit_c),
        .seg   (seg_c)
    );

    // Anode and segments registered together so they can never disagree.
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            Anode_Activate <= AN_DIG3;
            LED_out        <= SEG_0;
        end else begin
            Anode_Activate <= an_c;
            LED_out        <= seg_c;
        end
    end

endmodule

// File: tb/tb_score_display_unit.sv
// Self-checking bench for score_display_unit.
module tb_score_display_unit;

    localparam int SCAN_BITS = 10;
    localparam int SCAN_RUN  = 1 << (SCAN_BITS - 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Main DUT: CLK_HZ=10, REFRESH_BITS=4
    logic       rst_m = 1'b0, st_m = 1'b0;
    logic [3:0] an_m;
    logic [6:0] led_m;
    score_display_unit #(.CLK_HZ(10), .REFRESH_BITS(4)) u_main (
        .clk_100MHz(clk), .reset(rst_m), .status(st_m),
        .Anode_Activate(an_m), .LED_out(led_m));

    // Fast DUT: one step per running cycle, used to reach the carry/wrap cases
    logic       rst_f = 1'b0, st_f = 1'b0;
    logic [3:0] an_f;
    logic [6:0] led_f;
    score_display_unit #(.CLK_HZ(1), .REFRESH_BITS(4)) u_fast (
        .clk_100MHz(clk), .reset(rst_f), .status(st_f),
        .Anode_Activate(an_f), .LED_out(led_f));

    // Scan DUT: longer refresh counter for multiplex timing
    logic       rst_s = 1'b0, st_s = 1'b1;
    logic [3:0] an_s;
    logic [6:0] led_s;
    score_display_unit #(.CLK_HZ(10), .REFRESH_BITS(SCAN_BITS)) u_scan (
        .clk_100MHz(clk), .reset(rst_s), .status(st_s),
        .Anode_Activate(an_s), .LED_out(led_s));

    function automatic logic [6:0] seg_of(int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    // pos 3 = thousands ... pos 0 = ones
    function automatic int digit_of(int v, int pos);
        return (v / (10 ** pos)) % 10;
    endfunction

    function automatic logic [27:0] frame_of(int v);
        return {seg_of(digit_of(v, 3)), seg_of(digit_of(v, 2)),
                seg_of(digit_of(v, 1)), seg_of(digit_of(v, 0))};
    endfunction

    // Reference model for the main DUT: elapsed running cycles -> seconds.
    int         m_score = 0, m_phase = 0, m_cyc = 0;
    logic [3:0] m_an  = 4'b0111;
    logic [6:0] m_led = 7'b0000001;
    bit         check_en = 0;

    always @(posedge clk) begin
        int slot;
        if (!rst_m) begin
            m_score = 0; m_phase = 0; m_cyc = 0;
            m_an = 4'b0111; m_led = seg_of(0);
        end else begin
            slot  = (m_cyc / 4) % 4;
            m_an  = ~(4'b1000 >> slot);
            m_led = seg_of(digit_of(m_score, 3 - slot));
            m_cyc = (m_cyc + 1) % 16;
            if (st_m) begin
                m_phase = m_phase + 1;
                if (m_phase == 10) begin
                    m_phase = 0;
                    m_score = (m_score + 1) % 10000;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            n_cmp++;
            if (an_m !== m_an || led_m !== m_led) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t: got an=%b led=%b expected an=%b led=%b",
                         $time, an_m, led_m, m_an, m_led);
            end
        end
    end

    // Last pattern seen in each slot, captured from the pins.
    logic [6:0] shown_m [4];
    logic [6:0] shown_f [4];
    always @(negedge clk) begin
        case (an_m)
            4'b0111: shown_m[3] = led_m;
            4'b1011: shown_m[2] = led_m;
            4'b1101: shown_m[1] = led_m;
            4'b1110: shown_m[0] = led_m;
            default: ;
        endcase
        case (an_f)
            4'b0111: shown_f[3] = led_f;
            4'b1011: shown_f[2] = led_f;
            4'b1101: shown_f[1] = led_f;
            4'b1110: shown_f[0] = led_f;
            default: ;
        endcase
    end

    // Multiplex scan checks on the scan DUT.
    bit         scan_en = 0, scan_first = 1;
    int         scan_len = 0;
    logic [3:0] scan_prev = 4'b0111;
    always @(negedge clk) begin
        if (scan_en) begin
            n_cmp++;
            if ($countones(~an_s) != 1) begin
                n_fail++;
                $display("FAIL scan_onecold t=%0t: got %b expected exactly one low bit", $time, an_s);
            end
            if (an_s != scan_prev) begin
                n_cmp++;
                if (an_s != {scan_prev[0], scan_prev[3:1]}) begin
                    n_fail++;
                    $display("FAIL scan_order: got %b expected %b", an_s, {scan_prev[0], scan_prev[3:1]});
                end
                if (!scan_first) begin
                    n_cmp++;
                    if (scan_len != SCAN_RUN) begin
                        n_fail++;
                        $display("FAIL scan_dwell: got %0d cycles expected %0d", scan_len, SCAN_RUN);
                    end
                end
                scan_first = 0;
                scan_len   = 1;
                scan_prev  = an_s;
            end else begin
                scan_len++;
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        rst_s     = 1'b1;
        scan_prev = 4'b0111;
        scan_len  = 0;
        scan_en   = 1;
    end

    typedef struct {
        string name;
        logic  rst;
        logic  st;
        int    n;
        int    exp_score;
    } vec_t;
    vec_t tbl [12];

    task automatic run_m(input logic r, input logic s, input int n);
        for (int i = 0; i < n; i++) begin
            rst_m = r; st_m = s;
            @(negedge clk);
        end
    endtask

    task automatic run_f(input logic r, input logic s, input int n);
        for (int i = 0; i < n; i++) begin
            rst_f = r; st_f = s;
            @(negedge clk);
        end
    endtask

    task automatic check_main(input string name, input int v);
        logic [27:0] got;
        run_m(1'b1, 1'b0, 20);
        got = {shown_m[3], shown_m[2], shown_m[1], shown_m[0]};
        n_cmp++;
        if (got !== frame_of(v)) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (score %0d)", name, got, frame_of(v), v);
        end
    endtask

    task automatic check_fast(input string name, input int v);
        logic [27:0] got;
        run_f(1'b1, 1'b0, 20);
        got = {shown_f[3], shown_f[2], shown_f[1], shown_f[0]};
        n_cmp++;
        if (got !== frame_of(v)) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (score %0d)", name, got, frame_of(v), v);
        end
    endtask

    initial begin
        tbl[0]  = '{"reset_hold",    1'b0, 1'b0,   2, 0};
        tbl[1]  = '{"count_20",      1'b1, 1'b1,  20, 2};
        tbl[2]  = '{"count_to_3",    1'b1, 1'b1,  10, 3};
        tbl[3]  = '{"pause_100",     1'b1, 1'b0, 100, 3};
        tbl[4]  = '{"partial_4",     1'b1, 1'b1,   4, 3};
        tbl[5]  = '{"pause_50",      1'b1, 1'b0,  50, 3};
        tbl[6]  = '{"partial_9",     1'b1, 1'b1,   5, 3};
        tbl[7]  = '{"resume_tick",   1'b1, 1'b1,   1, 4};
        tbl[8]  = '{"count_to_5",    1'b1, 1'b1,  10, 5};
        tbl[9]  = '{"reset_mid",     1'b0, 1'b1,   1, 0};
        tbl[10] = '{"post_reset_9",  1'b1, 1'b1,   9, 0};
        tbl[11] = '{"post_reset_10", 1'b1, 1'b1,   1, 1};

        rst_m = 1'b0; st_m = 1'b0;
        @(negedge clk);
        check_en = 1;

        for (int i = 0; i < 12; i++) begin
            run_m(tbl[i].rst, tbl[i].st, tbl[i].n);
            check_main(tbl[i].name, tbl[i].exp_score);
        end

        // Random status/reset traffic against the cycle model.
        for (int i = 0; i < 2000; i++) begin
            run_m(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), 1);
        end
        check_main("random_end", m_score);

        // Carry and wrap sequences on the fast instance.
        run_f(1'b0, 1'b0, 2);
        check_fast("fast_reset", 0);
        run_f(1'b1, 1'b1, 9);
        check_fast("reach_0009", 9);
        run_f(1'b1, 1'b1, 1);
        check_fast("carry_0010", 10);
        run_f(1'b1, 1'b1, 989);
        check_fast("reach_0999", 999);
        run_f(1'b1, 1'b1, 1);
        check_fast("carry_1000", 1000);
        run_f(1'b1, 1'b1, 8999);
        check_fast("reach_9999", 9999);
        run_f(1'b1, 1'b1, 1);
        check_fast("wrap_0000", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
